// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the LoongArch pipeline stages: reset vector and
// inter-stage bus layouts used by fetch and decode when packing/unpacking.
package cpu_defs_pkg;

  localparam logic [31:0] RESET_PC        = 32'h1c000000;
  localparam int          FS_TO_DS_BUS_WD = 64;
  localparam int          BR_BUS_WD       = 33;

  // {pc, inst} as carried from fetch to decode
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_to_ds_bus_t;

  // {br_taken, br_target} as returned from decode to fetch
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  function automatic logic [FS_TO_DS_BUS_WD-1:0] pack_fs_to_ds(
    input logic [31:0] pc,
    input logic [31:0] inst
  );
    fs_to_ds_bus_t bus;
    bus.pc   = pc;
    bus.inst = inst;
    return bus;
  endfunction

  function automatic logic [BR_BUS_WD-1:0] pack_br(
    input logic        taken,
    input logic [31:0] target
  );
    br_bus_t bus;
    bus.taken  = taken;
    bus.target = target;
    return bus;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// SRAM, buffers the fetched word across decode stalls and handles redirects.
module if_stage
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_pend_target_q, br_pend_target_d;

  logic        fs_allowin;
  logic        issue;
  logic [31:0] nextpc;

  assign fs_allowin = ~fs_valid_q | ds_allowin;
  assign issue      = ~reset & fs_allowin;

  // A live redirect beats a remembered one, which beats sequential fetch
  assign nextpc = br_taken  ? br_target        :
                  br_pend_q ? br_pend_target_q :
                              fs_pc_q + 32'd4;

  assign inst_sram_en    = issue;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'd0;

  assign fs_to_ds_valid = fs_valid_q & ~br_taken & ~reset;
  assign fs_to_ds_pc    = fs_pc_q;
  assign fs_to_ds_inst  = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;

  always_comb begin
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    inst_buf_d       = inst_buf_q;
    inst_buf_valid_d = inst_buf_valid_q;
    br_pend_d        = br_pend_q;
    br_pend_target_d = br_pend_target_q;

    if (issue) begin
      fs_pc_d          = nextpc;
      fs_valid_d       = 1'b1;
      br_pend_d        = 1'b0;
      inst_buf_valid_d = 1'b0;
    end else if (br_taken) begin
      // Stalled redirect: squash the held bundle and replay the target later
      fs_valid_d       = 1'b0;
      inst_buf_valid_d = 1'b0;
      br_pend_d        = 1'b1;
      br_pend_target_d = br_target;
    end else if (fs_valid_q && !inst_buf_valid_q) begin
      // SRAM output is only good for one cycle, so keep it for the stall
      inst_buf_d       = inst_sram_rdata;
      inst_buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      inst_buf_q       <= 32'd0;
      inst_buf_valid_q <= 1'b0;
      br_pend_q        <= 1'b0;
      br_pend_target_q <= 32'd0;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      inst_buf_q       <= inst_buf_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      br_pend_q        <= br_pend_d;
      br_pend_target_q <= br_pend_target_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios then random stall/redirect/reset
// traffic, with delivered bundles checked against an in-order PC-stream model.
module tb_if_stage;
  import cpu_defs_pkg::*;

  localparam logic [31:0] MAGIC = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ds_allowin = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc;
  logic [31:0] fs_to_ds_inst;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'd0;

  int assertsDone = 0;
  int failures    = 0;
  int accepts     = 0;

  // Expected program-order PCs of the bundles decode will accept
  logic [31:0] expQ[$];
  logic [31:0] lastPushed = RESET_PC;

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_pc     (fs_to_ds_pc),
    .fs_to_ds_inst   (fs_to_ds_inst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  // SRAM model: garbage whenever no request was made
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ MAGIC;
    else              inst_sram_rdata <= $urandom;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertsDone++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic allow, input logic br,
                               input logic [31:0] tgt);
    @(posedge clk);
    #1;
    reset      = rst;
    ds_allowin = allow;
    br_taken   = br & ~rst;
    br_target  = tgt;
    if (rst) begin
      expQ.delete();
      expQ.push_back(RESET_PC);
      lastPushed = RESET_PC;
    end else if (br) begin
      expQ.delete();
      expQ.push_back(tgt);
      lastPushed = tgt;
    end
    while (expQ.size() < 4) begin
      lastPushed = lastPushed + 32'd4;
      expQ.push_back(lastPushed);
    end
    #2;
  endtask

  // Monitor: every accepted bundle must be the next PC of the stream
  initial begin
    logic [31:0] expPc;
    forever begin
      @(negedge clk);
      if (reset) begin
        checkOutput("valid_in_reset", {31'd0, fs_to_ds_valid}, 32'd0);
      end else if (fs_to_ds_valid && ds_allowin) begin
        if (expQ.size() == 0) begin
          assertsDone++;
          failures++;
          $display("[TB] FAIL unexpected_bundle: got pc %h, expected none", fs_to_ds_pc);
        end else begin
          expPc = expQ.pop_front();
          checkOutput("bundle_pc", fs_to_ds_pc, expPc);
          checkOutput("bundle_inst", fs_to_ds_inst, expPc ^ MAGIC);
          accepts++;
        end
      end
    end
  end

  initial begin
    logic        rRst, rAllow, rBr;
    logic [31:0] rTgt;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("reset_en", {31'd0, inst_sram_en}, 32'd0);
    checkOutput("reset_addr", inst_sram_addr, RESET_PC);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("first_en", {31'd0, inst_sram_en}, 32'd1);
    checkOutput("first_addr", inst_sram_addr, RESET_PC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("first_valid", {31'd0, fs_to_ds_valid}, 32'd1);
    checkOutput("first_pc", fs_to_ds_pc, RESET_PC);
    checkOutput("second_addr", inst_sram_addr, RESET_PC + 32'd4);

    // Decode stall on the second bundle
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("stall_en", {31'd0, inst_sram_en}, 32'd0);
      checkOutput("stall_pc", fs_to_ds_pc, RESET_PC + 32'd4);
      checkOutput("stall_inst", fs_to_ds_inst, (RESET_PC + 32'd4) ^ MAGIC);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h1c000100);
    checkOutput("redir_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    checkOutput("redir_addr", inst_sram_addr, 32'h1c000100);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("redir_pc", fs_to_ds_pc, 32'h1c000100);

    // Redirect while stalled
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1c000200);
    checkOutput("sredir_en", {31'd0, inst_sram_en}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("sredir_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    checkOutput("sredir_en2", {31'd0, inst_sram_en}, 32'd1);
    checkOutput("sredir_addr", inst_sram_addr, 32'h1c000200);

    // Two back-to-back redirects while stalled
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1c000300);
    checkOutput("dredir_en", {31'd0, inst_sram_en}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1c000400);
    checkOutput("dredir_addr", inst_sram_addr, 32'h1c000400);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("dredir_pc", fs_to_ds_pc, 32'h1c000400);

    // Reset with buffered instruction and pending redirect
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1c000500);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("mreset_en", {31'd0, inst_sram_en}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("mreset_addr", inst_sram_addr, RESET_PC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("mreset_pc", fs_to_ds_pc, RESET_PC);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rRst   = ($urandom % 100) == 0;
      rAllow = ($urandom % 4) != 0;
      rBr    = ($urandom % 12) == 0;
      rTgt   = $urandom & 32'hfffffffc;
      applyStimulus(rRst, rAllow, rBr, rTgt);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("min_accepts", {31'd0, accepts >= 1000}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertsDone, failures);
    $finish;
  end

endmodule
